// File: rtl/ser_host_pkg.sv
// Shared definitions for the serial-line bus initiator: FSM states, status bits,
// register addresses and bitrate codes.
package ser_host_pkg;

    typedef enum logic [2:0] {
        S_CFG  = 3'd0,
        S_GAP  = 3'd1,
        S_POLL = 3'd2,
        S_DEC  = 3'd3,
        S_WR   = 3'd4,
        S_RD   = 3'd5
    } state_t;

    localparam int RCV_RDY = 0;
    localparam int XMT_RDY = 1;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    typedef logic [2:0] baud_t;
    localparam baud_t BAUD_MIN       = 3'd0;
    localparam baud_t BAUD_9600_50M  = 3'd2;
    localparam baud_t BAUD_MAX       = 3'd7;

    function automatic logic [31:0] ctrl_word(input baud_t code);
        return {29'b0, code};
    endfunction

    function automatic logic [31:0] data_word(input logic [7:0] b);
        return {24'b0, b};
    endfunction

endpackage

// File: rtl/ser_host_if.sv
// Register-port bundle between the host initiator (master) and the serial
// line interface (slave); the slave acks combinationally with stb.
interface ser_host_if;
    logic        bus_stb;
    logic        bus_we;
    logic        bus_addr;
    logic [31:0] bus_dout;
    logic [31:0] bus_din;
    logic        bus_ack;

    modport master (
        output bus_stb, bus_we, bus_addr, bus_dout,
        input  bus_din, bus_ack
    );

    modport slave (
        input  bus_stb, bus_we, bus_addr, bus_dout,
        output bus_din, bus_ack
    );
endinterface

// File: rtl/ser_host_fifo.sv
// Small synchronous FIFO with an extra pointer bit for full/empty; the head
// word is read combinationally and forced to zero while empty.
module ser_host_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_host.sv
// Hardware-only initiator for the serial line interface: programs the bitrate,
// then polls status and shuttles bytes between client streams and the data register.
module ser_host
    import ser_host_pkg::*;
#(
    parameter logic [2:0] BAUD_SEL = 3'h2,
    parameter int         RX_DEPTH = 4,
    parameter int         RX_AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    ser_host_if.master  bus,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready
);

    state_t      r_state;
    logic        r_stb;
    logic        r_we;
    logic        r_addr;
    logic [31:0] r_dout;
    logic        r_rcv_rdy;
    logic        r_xmt_rdy;
    logic        r_last_rx;
    logic        r_tx_full;
    logic [7:0]  r_tx_hold;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_can_tx;
    logic        w_can_rx;
    logic        w_serve_tx;
    logic        w_ack_wr;
    logic        w_ack_rd;

    assign bus.bus_stb  = r_stb;
    assign bus.bus_we   = r_we;
    assign bus.bus_addr = r_addr;
    assign bus.bus_dout = r_dout;

    assign w_can_tx   = r_tx_full && r_xmt_rdy;
    assign w_can_rx   = r_rcv_rdy && !w_fifo_full;
    // With both sides ready, alternate so neither direction starves.
    assign w_serve_tx = w_can_tx && (!w_can_rx || r_last_rx);
    assign w_ack_wr   = (r_state == S_WR) && r_stb && bus.bus_ack;
    assign w_ack_rd   = (r_state == S_RD) && r_stb && bus.bus_ack;

    assign tx_ready = !r_tx_full;
    assign rx_valid = !w_fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CFG;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 1'b0;
            r_dout    <= '0;
            r_rcv_rdy <= 1'b0;
            r_xmt_rdy <= 1'b0;
            r_last_rx <= 1'b0;
        end else begin
            case (r_state)
                S_CFG: begin
                    if (!r_stb) begin
                        r_stb  <= 1'b1;
                        r_we   <= 1'b1;
                        r_addr <= ADDR_CTRL;
                        r_dout <= ctrl_word(BAUD_SEL);
                    end else if (bus.bus_ack) begin
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= 1'b0;
                        r_dout  <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_stb   <= 1'b1;
                    r_we    <= 1'b0;
                    r_addr  <= ADDR_CTRL;
                    r_state <= S_POLL;
                end
                S_POLL: begin
                    if (r_stb && bus.bus_ack) begin
                        r_stb     <= 1'b0;
                        r_addr    <= 1'b0;
                        r_rcv_rdy <= bus.bus_din[RCV_RDY];
                        r_xmt_rdy <= bus.bus_din[XMT_RDY];
                        r_state   <= S_DEC;
                    end
                end
                S_DEC: begin
                    r_stb <= 1'b1;
                    if (w_serve_tx) begin
                        r_we    <= 1'b1;
                        r_addr  <= ADDR_DATA;
                        r_dout  <= data_word(r_tx_hold);
                        r_state <= S_WR;
                    end else if (w_can_rx) begin
                        r_we    <= 1'b0;
                        r_addr  <= ADDR_DATA;
                        r_state <= S_RD;
                    end else begin
                        r_we    <= 1'b0;
                        r_addr  <= ADDR_CTRL;
                        r_state <= S_POLL;
                    end
                end
                S_WR: begin
                    if (w_ack_wr) begin
                        r_stb     <= 1'b0;
                        r_we      <= 1'b0;
                        r_dout    <= '0;
                        r_last_rx <= 1'b0;
                        r_state   <= S_GAP;
                    end
                end
                S_RD: begin
                    if (w_ack_rd) begin
                        r_stb     <= 1'b0;
                        r_last_rx <= 1'b1;
                        r_state   <= S_GAP;
                    end
                end
                default: begin
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                    r_addr  <= 1'b0;
                    r_dout  <= '0;
                    r_state <= S_CFG;
                end
            endcase
        end
    end

    // Holding register: accept and retire are mutually exclusive since accept needs it empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_full <= 1'b0;
            r_tx_hold <= '0;
        end else if (tx_valid && !r_tx_full) begin
            r_tx_full <= 1'b1;
            r_tx_hold <= tx_data;
        end else if (w_ack_wr) begin
            r_tx_full <= 1'b0;
        end
    end

    ser_host_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH),
        .AW    (RX_AW)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_ack_rd),
        .i_din   (bus.bus_din[7:0]),
        .i_pop   (rx_ready),
        .o_dout  (rx_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_ser_host.sv
// Directed bench for ser_host against a register-port responder with
// programmable ack latency, status word and receive byte table.
module tb_ser_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;

    ser_host_if bus_if ();

    ser_host #(
        .BAUD_SEL (3'h2),
        .RX_DEPTH (4),
        .RX_AW    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    // Responder model state
    logic [31:0] status = 32'h0;
    int          ack_lat = 0;
    int          m_wait = 0;
    logic [7:0]  rx_src [0:63];
    logic [5:0]  rx_idx = 6'd0;

    assign bus_if.bus_ack = bus_if.bus_stb && (m_wait >= ack_lat);
    assign bus_if.bus_din = bus_if.bus_addr ? status : {24'h0, rx_src[rx_idx]};

    int          cyc = 0;
    int          n_txn = 0;
    int          cnt_cfg = 0, cnt_poll = 0, cnt_wr = 0, cnt_rd = 0;
    logic [31:0] last_wr = 32'h0;
    logic        log_we   [0:1023];
    logic        log_addr [0:1023];
    logic [31:0] log_dout [0:1023];
    int          log_cyc  [0:1023];
    logic        alt_mode = 1'b0;
    logic        have_last = 1'b0;
    logic        last_kind_wr = 1'b0;
    int          alt_viol = 0;
    logic        held = 1'b0;
    logic        h_we, h_addr;
    logic [31:0] h_dout;
    int          stab_viol = 0;
    logic        prev_ack = 1'b0;
    int          gap_viol = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_if.bus_stb && !bus_if.bus_ack) m_wait <= m_wait + 1;
        else                                   m_wait <= 0;

        if (bus_if.bus_stb && prev_ack) gap_viol <= gap_viol + 1;
        prev_ack <= bus_if.bus_stb && bus_if.bus_ack;

        if (bus_if.bus_stb && !bus_if.bus_ack) begin
            if (held && (bus_if.bus_we != h_we || bus_if.bus_addr != h_addr ||
                         bus_if.bus_dout != h_dout))
                stab_viol <= stab_viol + 1;
            held   <= 1'b1;
            h_we   <= bus_if.bus_we;
            h_addr <= bus_if.bus_addr;
            h_dout <= bus_if.bus_dout;
        end else begin
            held <= 1'b0;
        end

        if (bus_if.bus_stb && bus_if.bus_ack) begin
            $display("txn %0d cyc=%0d %s addr=%0d dout=%08h din=%08h", n_txn, cyc,
                     bus_if.bus_we ? "WR" : "RD", bus_if.bus_addr, bus_if.bus_dout, bus_if.bus_din);
            if (n_txn < 1024) begin
                log_we[n_txn[9:0]]   <= bus_if.bus_we;
                log_addr[n_txn[9:0]] <= bus_if.bus_addr;
                log_dout[n_txn[9:0]] <= bus_if.bus_dout;
                log_cyc[n_txn[9:0]]  <= cyc;
            end
            n_txn <= n_txn + 1;
            if (bus_if.bus_addr) begin
                if (bus_if.bus_we) cnt_cfg <= cnt_cfg + 1;
                else               cnt_poll <= cnt_poll + 1;
            end else begin
                if (alt_mode && have_last && (last_kind_wr == bus_if.bus_we))
                    alt_viol <= alt_viol + 1;
                have_last    <= 1'b1;
                last_kind_wr <= bus_if.bus_we;
                if (bus_if.bus_we) begin
                    cnt_wr  <= cnt_wr + 1;
                    last_wr <= bus_if.bus_dout;
                end else begin
                    cnt_rd <= cnt_rd + 1;
                    rx_idx <= rx_idx + 6'd1;
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int r0, w0, d0, p0, n0;

    initial begin
        rx_src[0] = 8'h5A;
        for (int i = 1; i < 64; i++) rx_src[i] = 8'(i);

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_stb",      32'(bus_if.bus_stb),  32'd0);
        check_eq("rst_we",       32'(bus_if.bus_we),   32'd0);
        check_eq("rst_addr",     32'(bus_if.bus_addr), 32'd0);
        check_eq("rst_dout",     bus_if.bus_dout,      32'd0);
        check_eq("rst_tx_ready", 32'(tx_ready),        32'd1);
        check_eq("rst_rx_valid", 32'(rx_valid),        32'd0);
        check_eq("rst_rx_data",  32'(rx_data),         32'd0);

        // Bitrate write followed by first poll two cycles later
        rst = 1'b0;
        for (int i = 0; i < 20 && n_txn < 2; i++) @(negedge clk);
        check_eq("cfg_txn_count", 32'(n_txn >= 2), 32'd1);
        check_eq("cfg_we",    32'(log_we[0]),   32'd1);
        check_eq("cfg_addr",  32'(log_addr[0]), 32'd1);
        check_eq("cfg_dout",  log_dout[0],      32'h00000002);
        check_eq("poll_we",   32'(log_we[1]),   32'd0);
        check_eq("poll_addr", 32'(log_addr[1]), 32'd1);
        check_eq("cfg_to_poll_cycles", 32'(log_cyc[1] - log_cyc[0]), 32'd2);

        // TX path
        tx_data = 8'h41; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_eq("tx_ready_drop", 32'(tx_ready), 32'd0);
        repeat (30) @(negedge clk);
        check_eq("tx_no_write_status0", 32'(cnt_wr), 32'd0);
        status = 32'h2;
        for (int i = 0; i < 20 && cnt_wr != 1; i++) @(negedge clk);
        check_eq("tx_write_count", 32'(cnt_wr), 32'd1);
        check_eq("tx_write_data", last_wr, 32'h00000041);
        check_eq("tx_ready_back", 32'(tx_ready), 32'd1);
        repeat (20) @(negedge clk);
        check_eq("tx_single_write", 32'(cnt_wr), 32'd1);
        status = 32'h0;

        // RX path
        r0 = cnt_rd;
        status = 32'h1;
        for (int i = 0; i < 20 && cnt_rd != r0 + 1; i++) @(negedge clk);
        status = 32'h0;
        check_eq("rx_read_count", 32'(cnt_rd - r0), 32'd1);
        check_eq("rx_valid_set", 32'(rx_valid), 32'd1);
        check_eq("rx_data_5a", 32'(rx_data), 32'h5A);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_eq("rx_valid_clear", 32'(rx_valid), 32'd0);

        // RX backpressure: FIFO fills at 4 entries
        r0 = cnt_rd;
        status = 32'h1;
        repeat (60) @(negedge clk);
        check_eq("bp_reads_4", 32'(cnt_rd - r0), 32'd4);
        p0 = cnt_poll;
        repeat (15) @(negedge clk);
        check_eq("bp_still_4", 32'(cnt_rd - r0), 32'd4);
        check_eq("bp_polling", 32'(cnt_poll > p0), 32'd1);
        check_eq("bp_head_1", 32'(rx_data), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("bp_reads_5", 32'(cnt_rd - r0), 32'd5);
        status = 32'h0;
        repeat (5) @(negedge clk);
        for (int k = 2; k <= 5; k++) begin
            check_eq($sformatf("bp_order_%0d", k), 32'(rx_data), 32'(k));
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        check_eq("bp_drained", 32'(rx_valid), 32'd0);

        // Arbitration with both sides always ready
        rx_ready = 1'b1;
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        status   = 32'h3;
        w0 = cnt_wr; d0 = cnt_rd;
        alt_mode = 1'b1;
        repeat (120) @(negedge clk);
        alt_mode = 1'b0;
        check_eq("arb_alternate", 32'(alt_viol), 32'd0);
        check_eq("arb_writes", 32'(cnt_wr - w0 >= 10), 32'd1);
        check_eq("arb_reads", 32'(cnt_rd - d0 >= 10), 32'd1);
        tx_valid = 1'b0;
        status = 32'h2;
        for (int i = 0; i < 40 && !tx_ready; i++) @(negedge clk);
        check_eq("arb_tx_drained", 32'(tx_ready), 32'd1);
        status = 32'h0;
        repeat (5) @(negedge clk);

        // Slow ack, then reset in the middle of a data write
        ack_lat = 3;
        tx_data = 8'h77; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        w0 = cnt_wr;
        repeat (6) @(negedge clk);
        status = 32'h2;
        for (int i = 0; i < 40 && !(bus_if.bus_stb && bus_if.bus_we && !bus_if.bus_addr); i++)
            @(negedge clk);
        check_eq("slow_wr_stb", 32'(bus_if.bus_stb && bus_if.bus_we && !bus_if.bus_addr), 32'd1);
        check_eq("slow_wr_dout", bus_if.bus_dout, 32'h00000077);
        @(negedge clk);
        check_eq("slow_wr_hold_stb", 32'(bus_if.bus_stb), 32'd1);
        check_eq("slow_wr_hold_dout", bus_if.bus_dout, 32'h00000077);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_stb", 32'(bus_if.bus_stb), 32'd0);
        check_eq("async_rst_tx_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n0 = n_txn;
        for (int i = 0; i < 40 && n_txn <= n0; i++) @(negedge clk);
        check_eq("recfg_seen", 32'(n_txn > n0), 32'd1);
        check_eq("recfg_we",   32'(log_we[n0[9:0]]),   32'd1);
        check_eq("recfg_addr", 32'(log_addr[n0[9:0]]), 32'd1);
        check_eq("recfg_dout", log_dout[n0[9:0]],      32'h00000002);
        check_eq("aborted_wr_not_done", 32'(cnt_wr - w0), 32'd0);
        check_eq("tx_ready_after_rst", 32'(tx_ready), 32'd1);
        repeat (20) @(negedge clk);
        check_eq("pending_tx_discarded", 32'(cnt_wr - w0), 32'd0);
        check_eq("bus_stable_while_waiting", 32'(stab_viol), 32'd0);
        check_eq("no_back_to_back_stb", 32'(gap_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
